dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised data memory for the single-cycle/multi-cycle RISC-V cores, replacing the fixed 64-word word-only RAM. Supports RV32I byte, halfword and word loads/stores with sign/zero extension and alignment checking. Requests use a valid/ready handshake, responses are registered, and a memory-mapped LED register is decoded. Sits between the core's load/store path and the board LEDs.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words; power of two, ≥ 2.
- LED_W, 1: LED register width, 1..32.
- LED_ADDR, 32'h0000_1000: word-aligned byte address of the LED register; must lie outside the RAM range.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted.
- led  out  LED_W  LED register contents.

## Operation
- Accept: req_valid && req_ready at a rising edge. req_ready = !rsp_valid || rsp_ready (single response slot, combinational).
- Word index = req_addr[2 +: log2(DEPTH_WORDS)]. Lane = req_addr[1:0].
- RAM hit: req_addr[31:2] < DEPTH_WORDS. LED hit: req_addr[31:2] == LED_ADDR[31:2]. Anything else is an error.
- Error if any of the following: no hit; funct3 not in {000,001,010,100,101}; store with 100/101; H/HU with addr[0]=1; W with addr[1:0]≠0. An error writes nothing. Its response has rsp_err=1 and rsp_rdata=0.
- Store byte mask: B → 1 << lane; H → 4'b0011 << lane; W → 4'b1111. The data is replicated to the lane, and only masked bytes are written.
- Load: select the lane from the stored word. B/H sign-extend from bit 7/15. BU/HU zero-extend. W passes through.
- LED register: stores apply the byte mask to bits [LED_W-1:0] only. Loads return the register zero-extended to 32 bits.
- Stores produce a response (ack) with rsp_rdata=0 and rsp_err=0.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, led=0. req_ready=1 while reset is deasserted and rsp_valid=0.
- Reset asserted mid-operation: any pending response is dropped immediately. No RAM or LED write occurs on an edge where reset is high.
- Store commits at the accepting edge.
- Load response: rsp_valid rises one cycle after accept, with rsp_rdata/rsp_err registered.
- Response hold: while rsp_valid && !rsp_ready, rsp_valid, rsp_rdata and rsp_err hold stable, and req_ready=0.
- Throughput: with rsp_ready held high, one request per cycle and one response per cycle.
- Same-edge response hand-off and new accept: the new response replaces the old one at that edge.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. There is no forwarding hazard, because the write commits before the read edge.

## Test plan
- Reset with req_valid=0: led=0, rsp_valid=0, req_ready=1. Asserting reset while a response is stalled clears rsp_valid in the same cycle (asynchronous).
- SW 0xDEADBEEF to 0x8, then LB 0x9 → 0xFFFFFFBE. LBU 0xB → 0x000000DE. LH 0xA → 0xFFFFDEAD. LHU 0x8 → 0x0000BEEF. LW 0x8 → 0xDEADBEEF.
- SW 0x11223344 to 0x4, SB 0xAA to 0x6, SH 0x5566 to 0x4, then LW 0x4 → 0x11AA5566.
- Errors, each with rsp_err=1, rsp_rdata=0 and no write (verify with a follow-up LW):
  - LH at 0x3;
  - SW at 0x2;
  - LW at DEPTH_WORDS*4;
  - funct3=011;
  - store with funct3=100.
- LED: SW 0x1 to LED_ADDR → led=1 the next cycle, LW LED_ADDR → 0x00000001. SB 0x0 to LED_ADDR+1 leaves led unchanged.
- Back-pressure: issue 4 back-to-back loads with rsp_ready low for 3 cycles after the first response. Required behaviour:
  - req_ready=0 while stalled;
  - the first response is held stable;
  - all 4 responses arrive in order with correct data;
  - full rate resumes once rsp_ready is high.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable RV32I data memory with a valid/ready request port,
// a single registered response slot and a memory-mapped LED register.
module dmem_lsu #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          LED_W       = 1,
    parameter logic [31:0] LED_ADDR    = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [LED_W-1:0] led
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    logic [31:0]      mem_r [DEPTH_WORDS];
    logic [LED_W-1:0] led_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_rdata_r;
    logic             rsp_err_r;

    logic             accept_s;
    logic [1:0]       lane_s;
    logic [AW-1:0]    word_idx_s;
    logic             ram_hit_s;
    logic             led_hit_s;
    size_e            size_s;
    logic             unsigned_s;
    logic             f3_ok_s;
    logic             align_ok_s;
    logic             err_s;
    logic [3:0]       mask_s;
    logic [31:0]      wdata_rep_s;
    logic             ram_we_s;
    logic             led_we_s;
    logic [LED_W-1:0] led_next_s;
    logic [31:0]      rd_word_s;
    logic [31:0]      lane_data_s;
    logic [31:0]      load_data_s;
    logic [31:0]      rsp_data_next_s;

    assign req_ready  = !rsp_valid_r || rsp_ready;
    assign accept_s   = req_valid && req_ready;
    assign lane_s     = req_addr[1:0];
    assign word_idx_s = req_addr[2 +: AW];
    assign ram_hit_s  = {2'b00, req_addr[31:2]} < DEPTH_L;
    assign led_hit_s  = req_addr[31:2] == LED_ADDR[31:2];

    // Decode funct3 into access size and extension mode.
    always_comb begin
        size_s     = SZ_W;
        unsigned_s = 1'b0;
        f3_ok_s    = 1'b1;
        case (req_funct3)
            3'b000: size_s = SZ_B;
            3'b001: size_s = SZ_H;
            3'b010: size_s = SZ_W;
            3'b100: begin
                size_s     = SZ_B;
                unsigned_s = 1'b1;
            end
            3'b101: begin
                size_s     = SZ_H;
                unsigned_s = 1'b1;
            end
            default: f3_ok_s = 1'b0;
        endcase
    end

    // Natural-alignment check and store byte mask for the decoded size.
    always_comb begin
        align_ok_s = 1'b1;
        mask_s     = 4'b1111;
        case (size_s)
            SZ_B: begin
                align_ok_s = 1'b1;
                mask_s     = 4'b0001 << lane_s;
            end
            SZ_H: begin
                align_ok_s = (req_addr[0] == 1'b0);
                mask_s     = 4'b0011 << lane_s;
            end
            SZ_W: begin
                align_ok_s = (req_addr[1:0] == 2'b00);
                mask_s     = 4'b1111;
            end
            default: begin
                align_ok_s = 1'b0;
                mask_s     = 4'b0000;
            end
        endcase
    end

    // Replicate right-aligned store data into every lane it could land in.
    always_comb begin
        wdata_rep_s = req_wdata;
        case (size_s)
            SZ_B:    wdata_rep_s = {4{req_wdata[7:0]}};
            SZ_H:    wdata_rep_s = {2{req_wdata[15:0]}};
            SZ_W:    wdata_rep_s = req_wdata;
            default: wdata_rep_s = req_wdata;
        endcase
    end

    assign err_s    = !(ram_hit_s || led_hit_s) || !f3_ok_s
                    || (req_we && unsigned_s) || !align_ok_s;
    assign ram_we_s = accept_s && req_we && !err_s && ram_hit_s;
    assign led_we_s = accept_s && req_we && !err_s && led_hit_s;

    // Byte-masked RAM write; an edge with reset high never commits a store.
    always_ff @(posedge clk) begin
        if (!reset && ram_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_s[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= wdata_rep_s[8*b +: 8];
                end
            end
        end
    end

    // LED bits take the store byte mask; bits beyond LED_W do not exist.
    always_comb begin
        led_next_s = led_r;
        for (int i = 0; i < LED_W; i++) begin
            if (mask_s[i/8]) begin
                led_next_s[i] = wdata_rep_s[i];
            end else begin
                led_next_s[i] = led_r[i];
            end
        end
    end

    // LED register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r <= '0;
        end else if (led_we_s) begin
            led_r <= led_next_s;
        end
    end

    assign rd_word_s   = mem_r[word_idx_s];
    assign lane_data_s = rd_word_s >> {lane_s, 3'b000};

    // Lane select and sign/zero extension of the load result.
    always_comb begin
        load_data_s = 32'h0000_0000;
        if (led_hit_s) begin
            load_data_s = 32'(led_r);
        end else begin
            case (size_s)
                SZ_B: begin
                    if (unsigned_s) begin
                        load_data_s = {24'h00_0000, lane_data_s[7:0]};
                    end else begin
                        load_data_s = {{24{lane_data_s[7]}}, lane_data_s[7:0]};
                    end
                end
                SZ_H: begin
                    if (unsigned_s) begin
                        load_data_s = {16'h0000, lane_data_s[15:0]};
                    end else begin
                        load_data_s = {{16{lane_data_s[15]}}, lane_data_s[15:0]};
                    end
                end
                SZ_W:    load_data_s = lane_data_s;
                default: load_data_s = 32'h0000_0000;
            endcase
        end
    end

    assign rsp_data_next_s = (req_we || err_s) ? 32'h0000_0000 : load_data_s;

    // Single response slot: a new accept overwrites, a hand-off alone empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rsp_data_next_s;
            rsp_err_r   <= err_s;
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign led       = led_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed, table-driven bench for dmem_lsu, plus hand-written back-pressure
// and reset-during-stall sequences.
module tb_dmem_lsu;
    localparam int          DEPTH = 64;
    localparam logic [31:0] LED_A = 32'h0000_1000;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        req_valid  = 1'b0;
    logic        req_ready;
    logic        req_we     = 1'b0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] req_addr   = 32'h0;
    logic [31:0] req_wdata  = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready  = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [0:0]  led;

    dmem_lsu #(.DEPTH_WORDS(DEPTH), .LED_W(1), .LED_ADDR(LED_A)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_led;
    } vec_t;

    vec_t vq[$];
    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] bp_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hA};
    logic [2:0]  bp_f3   [4] = '{3'b010, 3'b010, 3'b010, 3'b001};
    logic [31:0] bp_exp  [4] = '{32'h0102_0304, 32'h11AA_5566, 32'hDEAD_BEEF, 32'hFFFF_DEAD};
    int sent, rcv, stalls, cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input string n, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic e, input logic l);
        vec_t v;
        v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_rdata = rd; v.exp_err = e; v.exp_led = l;
        return v;
    endfunction

    // One request accepted at a posedge; response checked 1 time unit later.
    task automatic send(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        #1 chk({v.name, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk({v.name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({v.name, " err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({v.name, " led"}, 32'(led), 32'(v.exp_led));
    endtask

    initial begin
        vq.push_back(mk("sw0",       1'b1, 3'b010, 32'h0,         32'h0102_0304, 32'h0,          1'b0, 1'b0));
        vq.push_back(mk("sw8",       1'b1, 3'b010, 32'h8,         32'hDEAD_BEEF, 32'h0,          1'b0, 1'b0));
        vq.push_back(mk("lb9",       1'b0, 3'b000, 32'h9,         32'h0,         32'hFFFF_FFBE,  1'b0, 1'b0));
        vq.push_back(mk("lbuB",      1'b0, 3'b100, 32'hB,         32'h0,         32'h0000_00DE,  1'b0, 1'b0));
        vq.push_back(mk("lhA",       1'b0, 3'b001, 32'hA,         32'h0,         32'hFFFF_DEAD,  1'b0, 1'b0));
        vq.push_back(mk("lhu8",      1'b0, 3'b101, 32'h8,         32'h0,         32'h0000_BEEF,  1'b0, 1'b0));
        vq.push_back(mk("lw8",       1'b0, 3'b010, 32'h8,         32'h0,         32'hDEAD_BEEF,  1'b0, 1'b0));
        vq.push_back(mk("sw4",       1'b1, 3'b010, 32'h4,         32'h1122_3344, 32'h0,          1'b0, 1'b0));
        vq.push_back(mk("sb6",       1'b1, 3'b000, 32'h6,         32'h1234_56AA, 32'h0,          1'b0, 1'b0));
        vq.push_back(mk("sh4",       1'b1, 3'b001, 32'h4,         32'h9876_5566, 32'h0,          1'b0, 1'b0));
        vq.push_back(mk("lw4",       1'b0, 3'b010, 32'h4,         32'h0,         32'h11AA_5566,  1'b0, 1'b0));
        vq.push_back(mk("lh3_err",   1'b0, 3'b001, 32'h3,         32'h0,         32'h0,          1'b1, 1'b0));
        vq.push_back(mk("sw2_err",   1'b1, 3'b010, 32'h2,         32'hFFFF_FFFF, 32'h0,          1'b1, 1'b0));
        vq.push_back(mk("lw0",       1'b0, 3'b010, 32'h0,         32'h0,         32'h0102_0304,  1'b0, 1'b0));
        vq.push_back(mk("lw_oob",    1'b0, 3'b010, 32'(DEPTH*4),  32'h0,         32'h0,          1'b1, 1'b0));
        vq.push_back(mk("ld_f3_011", 1'b0, 3'b011, 32'h8,         32'h0,         32'h0,          1'b1, 1'b0));
        vq.push_back(mk("st_f3_011", 1'b1, 3'b011, 32'h8,         32'h0,         32'h0,          1'b1, 1'b0));
        vq.push_back(mk("st_f3_100", 1'b1, 3'b100, 32'h8,         32'h0,         32'h0,          1'b1, 1'b0));
        vq.push_back(mk("lw8_after", 1'b0, 3'b010, 32'h8,         32'h0,         32'hDEAD_BEEF,  1'b0, 1'b0));
        vq.push_back(mk("sh5_err",   1'b1, 3'b001, 32'h5,         32'h0,         32'h0,          1'b1, 1'b0));
        vq.push_back(mk("lw4_after", 1'b0, 3'b010, 32'h4,         32'h0,         32'h11AA_5566,  1'b0, 1'b0));
        vq.push_back(mk("sb_top",    1'b1, 3'b000, 32'(DEPTH*4-1),32'h0000_0080, 32'h0,          1'b0, 1'b0));
        vq.push_back(mk("lb_top",    1'b0, 3'b000, 32'(DEPTH*4-1),32'h0,         32'hFFFF_FF80,  1'b0, 1'b0));
        vq.push_back(mk("lw_1004",   1'b0, 3'b010, LED_A + 32'h4, 32'h0,         32'h0,          1'b1, 1'b0));
        vq.push_back(mk("led_sw",    1'b1, 3'b010, LED_A,         32'h0000_0001, 32'h0,          1'b0, 1'b1));
        vq.push_back(mk("led_lw",    1'b0, 3'b010, LED_A,         32'h0,         32'h0000_0001,  1'b0, 1'b1));
        vq.push_back(mk("led_sb1",   1'b1, 3'b000, LED_A + 32'h1, 32'h0,         32'h0,          1'b0, 1'b1));
        vq.push_back(mk("led_lw2",   1'b0, 3'b010, LED_A,         32'h0,         32'h0000_0001,  1'b0, 1'b1));
        vq.push_back(mk("led_sb0",   1'b1, 3'b000, LED_A,         32'h0000_0100, 32'h0,          1'b0, 1'b0));
        vq.push_back(mk("led_lw3",   1'b0, 3'b010, LED_A,         32'h0,         32'h0,          1'b0, 1'b0));
        vq.push_back(mk("led_sw_mis",1'b1, 3'b010, LED_A + 32'h2, 32'h0000_0001, 32'h0,          1'b1, 1'b0));
        vq.push_back(mk("led_sw_on", 1'b1, 3'b010, LED_A,         32'hFFFF_FFFF, 32'h0,          1'b0, 1'b1));

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1 chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset led", 32'(led), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        #1 chk("post-reset req_ready", 32'(req_ready), 32'd1);

        foreach (vq[i]) send(vq[i]);

        @(posedge clk);
        #1 chk("idle rsp_valid", 32'(rsp_valid), 32'd0);

        // Four back-to-back loads; first response stalled for 3 cycles.
        sent = 0; rcv = 0; stalls = 0;
        for (cyc = 0; cyc < 20 && rcv < 4; cyc++) begin
            @(negedge clk);
            rsp_ready = !(rsp_valid && stalls < 3);
            if (rsp_valid && stalls < 3) stalls++;
            req_valid = (sent < 4);
            if (sent < 4) begin
                req_we = 1'b0; req_funct3 = bp_f3[sent]; req_addr = bp_addr[sent];
            end
            #1;
            if (rsp_valid && !rsp_ready) begin
                chk("bp stall req_ready", 32'(req_ready), 32'd0);
                chk("bp held rdata", rsp_rdata, bp_exp[rcv]);
                chk("bp held err", 32'(rsp_err), 32'd0);
            end else if (sent < 4) begin
                chk("bp run req_ready", 32'(req_ready), 32'd1);
            end
            if (rsp_valid && rsp_ready) begin
                chk("bp rsp rdata", rsp_rdata, bp_exp[rcv]);
                chk("bp rsp err", 32'(rsp_err), 32'd0);
                rcv++;
            end
            if (req_valid && req_ready) sent++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("bp responses", 32'(rcv), 32'd4);
        chk("bp stall cycles", 32'(stalls), 32'd3);
        chk("bp total cycles", 32'(cyc), 32'd8);

        // Reset while a response is stalled; store presented during reset.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("stalled rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stalled rdata", rsp_rdata, 32'hDEAD_BEEF);
        reset = 1'b1;
        #1 chk("async reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async reset led", 32'(led), 32'd0);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("in-reset rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send(mk("lw8_post_rst", 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
